mul_rr_scheduler: RTL

//  Shares one pipelined multiplier (registered, fixed latency, no valid/ready) among NUM_REQ requesters.

---
 rtl/mul_sched_pkg.sv | 19 +
 rtl/mul_rr_scheduler_rr_arbiter.sv | 44 ++++
 rtl/mul_rr_scheduler.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mul_sched_pkg.sv
// Shared defaults and types for the multiplier round-robin scheduler.
package mul_sched_pkg;

  localparam int NUM_REQ_DEF     = 4;
  localparam int DATA_LEN_DEF    = 32;
  localparam int TAG_W_DEF       = 8;
  localparam int MUL_LATENCY_DEF = 2;
  localparam int ID_W_DEF        = $clog2(NUM_REQ_DEF);

  typedef logic [TAG_W_DEF-1:0] t_mul_tag;

  // One tracker entry: what the multiplier pipeline is carrying in a given stage.
  typedef struct packed {
    logic                valid;
    logic [ID_W_DEF-1:0] id;
    t_mul_tag            tag;
  } t_mul_slot;

endpackage

// File: rtl/mul_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, pointer advances past the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_id,
  output logic               grant_any
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    ptr_d     = ptr_q;
    idx       = '0;
    // Held in reset so no handshake is reported while the pipeline is being cleared.
    if (enable && !reset) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        idx = PTR_W'((int'(ptr_q) + off) % NUM_REQ);
        if (!grant_any && req[idx]) begin
          grant_any  = 1'b1;
          grant[idx] = 1'b1;
          grant_id   = idx;
          ptr_d      = PTR_W'((int'(idx) + 1) % NUM_REQ);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mul_rr_scheduler.sv
// Shares one fixed-latency pipelined multiplier among NUM_REQ requesters and
// routes each product back to its requester with the original tag.
module mul_rr_scheduler
  import mul_sched_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int DATA_LEN    = DATA_LEN_DEF,
  parameter int TAG_W       = TAG_W_DEF,
  parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_a,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_b,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_LEN-1:0]         rsp_result,
  output logic [TAG_W-1:0]            rsp_tag,
  output logic [DATA_LEN-1:0]         mul_a,
  output logic [DATA_LEN-1:0]         mul_b,
  input  logic [DATA_LEN-1:0]         mul_result,
  output logic                        busy,
  output logic [31:0]                 issue_count
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = MUL_LATENCY + 1;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [TAG_W-1:0] tag;
  } t_slot;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic                grant_any;

  logic [DATA_LEN-1:0] mul_a_q, mul_a_d;
  logic [DATA_LEN-1:0] mul_b_q, mul_b_d;
  t_slot               slot_q [DEPTH];
  t_slot               slot_d [DEPTH];
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_LEN-1:0] rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
  logic [31:0]         issue_count_q, issue_count_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req       (req_valid),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  always_comb begin
    mul_a_d       = '0;
    mul_b_d       = '0;
    slot_d[0]     = '0;
    issue_count_d = issue_count_q + 32'(grant_any);
    // Issue stage: winner's operands go to the multiplier, its id/tag enter the tracker.
    if (grant_any) begin
      mul_a_d         = req_a[int'(grant_id)*DATA_LEN +: DATA_LEN];
      mul_b_d         = req_b[int'(grant_id)*DATA_LEN +: DATA_LEN];
      slot_d[0].valid = 1'b1;
      slot_d[0].id    = grant_id;
      slot_d[0].tag   = req_tag[int'(grant_id)*TAG_W +: TAG_W];
    end
    for (int i = 1; i < DEPTH; i++) slot_d[i] = slot_q[i-1];

    // Response stage: the oldest tracker entry lines up with mul_result.
    rsp_valid_d  = '0;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    if (slot_q[DEPTH-1].valid) begin
      rsp_valid_d[slot_q[DEPTH-1].id] = 1'b1;
      rsp_result_d                    = mul_result;
      rsp_tag_d                       = slot_q[DEPTH-1].tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      rsp_valid_q   <= '0;
      rsp_result_q  <= '0;
      rsp_tag_q     <= '0;
      issue_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_tag_q     <= rsp_tag_d;
      issue_count_q <= issue_count_d;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy = busy | slot_q[i].valid;
  end

  assign req_ready   = grant;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_tag     = rsp_tag_q;
  assign issue_count = issue_count_q;

endmodule
